window_gen_5x5: RTL and testbench



---
 rtl/window_gen_5x5_if.sv | 40 ++++
 rtl/window_gen_5x5.sv | 141 ++++++++++++++
 tb/tb_window_gen_5x5.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/window_gen_5x5_if.sv
// Stream interface for window_gen_5x5: raster pixel input and 5x5 window output.
// Optional centre-coordinate outputs appear when WINDOW_COORD_EN is defined.
interface window_gen_5x5_if #(
  parameter int img_width       = 516,
  parameter int img_height      = 516,
  parameter int pixel_in_width  = 8,
  parameter int pixel_int_width = 9,
  parameter int kernel_size     = 5
);
  logic [pixel_in_width-1:0]                          in_pixel;
  logic                                               in_valid;
  logic                                               in_sof;
  logic                                               in_ready;
  logic [kernel_size*kernel_size*pixel_int_width-1:0] out_window;
  logic                                               out_valid;
  logic                                               out_ready;
  logic                                               out_eof;
`ifdef WINDOW_COORD_EN
  logic [$clog2(img_height)-1:0]                      out_row;
  logic [$clog2(img_width)-1:0]                       out_col;

  modport master (
    output in_pixel, in_valid, in_sof, out_ready,
    input  in_ready, out_window, out_valid, out_eof, out_row, out_col
  );
  modport slave (
    input  in_pixel, in_valid, in_sof, out_ready,
    output in_ready, out_window, out_valid, out_eof, out_row, out_col
  );
`else
  modport master (
    output in_pixel, in_valid, in_sof, out_ready,
    input  in_ready, out_window, out_valid, out_eof
  );
  modport slave (
    input  in_pixel, in_valid, in_sof, out_ready,
    output in_ready, out_window, out_valid, out_eof
  );
`endif
endinterface

// File: rtl/window_gen_5x5.sv
// Streaming 5x5 sliding-window generator. Four line memories hold the previous
// lines; each accepted pixel shifts one column into a 5x5 register array and,
// at interior positions, the whole array is presented as 25 zero-extended
// signed pixels (pixel1 = top-left oldest, pixel25 = newest).
// Optional macro WINDOW_COORD_EN adds out_row/out_col (window centre).
module window_gen_5x5 #(
  parameter int img_width       = 516,
  parameter int img_height      = 516,
  parameter int pixel_in_width  = 8,
  parameter int pixel_int_width = 9,
  parameter int kernel_size     = 5
) (
  input logic             clk,
  input logic             rst,
  window_gen_5x5_if.slave win_if
);
  localparam int K  = kernel_size;
  localparam int RW = $clog2(img_height);
  localparam int CW = $clog2(img_width);
  localparam int PW = pixel_in_width;
  localparam int OW = pixel_int_width;

  logic [RW-1:0] row_q, row_d, eff_row;
  logic [CW-1:0] col_q, col_d, eff_col;
  logic          out_valid_q, out_valid_d;
  logic          out_eof_q, out_eof_d;
  logic [PW-1:0] win_q [K][K];
  logic [PW-1:0] win_d [K][K];
  logic [PW-1:0] lb_q [K-1][img_width];
  logic [PW-1:0] tap [K];
  logic          in_ready, accept, qualify, last_pix;
`ifdef WINDOW_COORD_EN
  logic [RW-1:0] out_row_q, out_row_d;
  logic [CW-1:0] out_col_q, out_col_d;
`endif

  // An accepted in_sof pixel is (0,0) whatever the counters say.
  assign in_ready = !rst && !(out_valid_q && !win_if.out_ready);
  assign accept   = win_if.in_valid && in_ready;
  assign eff_row  = win_if.in_sof ? '0 : row_q;
  assign eff_col  = win_if.in_sof ? '0 : col_q;
  assign qualify  = (eff_row >= RW'(K-1)) && (eff_col >= CW'(K-1));
  assign last_pix = (eff_row == RW'(img_height-1)) && (eff_col == CW'(img_width-1));

  // Column taps: lb_q[0] holds line r-1, lb_q[K-2] holds line r-4.
  always_comb begin
    for (int i = 0; i < K-1; i++) tap[i] = lb_q[K-2-i][eff_col];
    tap[K-1] = win_if.in_pixel;
  end

  // Line memories cascade: read-before-write at the current column.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_q[0][eff_col] <= win_if.in_pixel;
      for (int i = 1; i < K-1; i++) lb_q[i][eff_col] <= lb_q[i-1][eff_col];
    end
  end

  // Shift the window left by one column and insert the new column on the right.
  always_comb begin
    win_d = win_q;
    if (accept) begin
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K-1; j++) win_d[i][j] = win_q[i][j+1];
        win_d[i][K-1] = tap[i];
      end
    end
  end

  // Raster counters and output qualifiers for the next cycle.
  always_comb begin
    row_d       = row_q;
    col_d       = col_q;
    out_valid_d = out_valid_q;
    out_eof_d   = out_eof_q;
`ifdef WINDOW_COORD_EN
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;
`endif
    if (accept) begin
      if (eff_col == CW'(img_width-1)) begin
        col_d = '0;
        row_d = (eff_row == RW'(img_height-1)) ? '0 : eff_row + 1'b1;
      end else begin
        col_d = eff_col + 1'b1;
        row_d = eff_row;
      end
      out_valid_d = qualify;
      out_eof_d   = last_pix;
`ifdef WINDOW_COORD_EN
      out_row_d   = eff_row - RW'(2);
      out_col_d   = eff_col - CW'(2);
`endif
    end else if (win_if.out_ready) begin
      out_valid_d = 1'b0;
      out_eof_d   = 1'b0;
    end
  end

  // State registers; line memories are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_q       <= '0;
      col_q       <= '0;
      out_valid_q <= 1'b0;
      out_eof_q   <= 1'b0;
      for (int i = 0; i < K; i++)
        for (int j = 0; j < K; j++) win_q[i][j] <= '0;
`ifdef WINDOW_COORD_EN
      out_row_q   <= '0;
      out_col_q   <= '0;
`endif
    end else begin
      row_q       <= row_d;
      col_q       <= col_d;
      out_valid_q <= out_valid_d;
      out_eof_q   <= out_eof_d;
      win_q       <= win_d;
`ifdef WINDOW_COORD_EN
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
`endif
    end
  end

  // Flatten the window, row-major, zero-extending each pixel.
  always_comb begin
    win_if.out_window = '0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        win_if.out_window[(i*K+j)*OW +: OW] = OW'(win_q[i][j]);
  end

  assign win_if.in_ready  = in_ready;
  assign win_if.out_valid = out_valid_q;
  assign win_if.out_eof   = out_eof_q;
`ifdef WINDOW_COORD_EN
  assign win_if.out_row   = out_row_q;
  assign win_if.out_col   = out_col_q;
`endif
endmodule

// File: tb/tb_window_gen_5x5.sv
// Directed bench for window_gen_5x5 on an 8x8 image with a scoreboard of
// expected windows built from a frame-array reference.
module tb_window_gen_5x5;
  localparam int W  = 8;
  localparam int H  = 8;
  localparam int K  = 5;
  localparam int OW = 9;
  localparam int WB = K*K*OW;
  localparam int RW = $clog2(H);
  localparam int CW = $clog2(W);

  typedef struct packed {
    logic [WB-1:0] win;
    logic          eof;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  window_gen_5x5_if #(.img_width(W), .img_height(H)) bus ();
  window_gen_5x5 #(.img_width(W), .img_height(H)) dut (
    .clk    (clk),
    .rst    (rst),
    .win_if (bus.slave)
  );

  exp_t       sb_q[$];
  logic [7:0] mdl [H][W];
  int         total    = 0;
  int         pass_cnt = 0;
  int         win_cnt  = 0;
  logic [8:0] last25   = '0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] pix(input int mode, input int r, input int c);
    logic [7:0] v;
    v = 8'(r*16 + c);
    case (mode)
      0:       return v;
      1:       return 8'hFF;
      default: return v ^ 8'hA5;
    endcase
  endfunction

  // Scoreboard consumer: every transfer is compared against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (bus.out_valid && bus.out_ready) begin
      win_cnt++;
      chk("sb_has_entry", 256'(sb_q.size() != 0), 256'(1));
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("window", 256'(bus.out_window), 256'(e.win));
        chk("eof", 256'(bus.out_eof), 256'(e.eof));
`ifdef WINDOW_COORD_EN
        chk("out_row", 256'(bus.out_row), 256'(e.row));
        chk("out_col", 256'(bus.out_col), 256'(e.col));
`endif
        if (bus.out_eof) last25 = bus.out_window[24*OW +: OW];
      end
    end
  end

  task automatic send_pixel(input int r, input int c, input logic [7:0] v, input logic sof);
    int   n;
    exp_t e;
    n = 0;
    bus.in_pixel = v;
    bus.in_valid = 1'b1;
    bus.in_sof   = sof;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("in_ready_timeout", 256'(bus.in_ready), 256'(1));
    mdl[r][c] = v;
    if (r >= 4 && c >= 4) begin
      e.win = '0;
      for (int k = 0; k < K*K; k++)
        e.win[k*OW +: OW] = {1'b0, mdl[r-4+k/5][c-4+k%5]};
      e.eof = (r == H-1) && (c == W-1);
      e.row = RW'(r-2);
      e.col = CW'(c-2);
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  // Sends raster positions with linear index in [first, last), optional idle gap.
  task automatic send_range(input int mode, input int gap, input logic sof, input int first, input int last);
    for (int i = first; i < last; i++) begin
      send_pixel(i / W, i % W, pix(mode, i / W, i % W), sof && (i == 0));
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic drain();
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic stall_proc();
    int            n;
    logic [WB-1:0] held;
    n = 0;
    @(posedge clk);
    #1;
    while (!bus.out_valid && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("stall_wait_valid", 256'(bus.out_valid), 256'(1));
    bus.out_ready = 1'b0;
    held = bus.out_window;
    repeat (3) begin
      @(negedge clk);
      chk("stall_in_ready", 256'(bus.in_ready), 256'(0));
      chk("stall_window", 256'(bus.out_window), 256'(held));
      chk("stall_valid", 256'(bus.out_valid), 256'(1));
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    // 1: reset
    rst           = 1'b1;
    bus.in_pixel  = '0;
    bus.in_valid  = 1'b0;
    bus.in_sof    = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_in_ready", 256'(bus.in_ready), 256'(0));
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 256'(bus.out_valid), 256'(0));
    chk("rst_out_window", 256'(bus.out_window), 256'(0));
    chk("rst_out_eof", 256'(bus.out_eof), 256'(0));
    chk("post_rst_in_ready", 256'(bus.in_ready), 256'(1));
    @(posedge clk);
    #1;

    // 2: continuous frame, first-window latency and contents, last window
    start = win_cnt;
    send_range(0, 0, 1'b1, 0, 4*W+5);
    @(negedge clk);
    chk("first_valid", 256'(bus.out_valid), 256'(1));
    chk("first_p1", 256'(bus.out_window[0 +: OW]), 256'(9'h000));
    chk("first_p13", 256'(bus.out_window[12*OW +: OW]), 256'(9'h022));
    chk("first_p25", 256'(bus.out_window[24*OW +: OW]), 256'(9'h044));
    @(posedge clk);
    #1;
    send_range(0, 0, 1'b0, 4*W+5, W*H);
    drain();
    chk("t2_count", 256'(win_cnt - start), 256'(16));
    chk("t2_sb_empty", 256'(sb_q.size()), 256'(0));
    chk("t2_last_p25", 256'(last25), 256'(9'h077));

    // 3: downstream stall on the first window
    start = win_cnt;
    fork
      send_range(0, 0, 1'b1, 0, W*H);
      stall_proc();
    join
    drain();
    chk("t3_count", 256'(win_cnt - start), 256'(16));
    chk("t3_sb_empty", 256'(sb_q.size()), 256'(0));

    // 4: in_valid 1,0,0,1,...
    start = win_cnt;
    send_range(0, 2, 1'b1, 0, W*H);
    drain();
    chk("t4_count", 256'(win_cnt - start), 256'(16));
    chk("t4_sb_empty", 256'(sb_q.size()), 256'(0));

    // 5: all-0xFF frame then a patterned frame back-to-back via counter wrap
    start = win_cnt;
    send_range(1, 0, 1'b1, 0, W*H);
    send_range(0, 0, 1'b0, 0, W*H);
    drain();
    chk("t5_count", 256'(win_cnt - start), 256'(32));
    chk("t5_sb_empty", 256'(sb_q.size()), 256'(0));

    // 6a: frame interrupted by in_sof at counter position (5,3)
    start = win_cnt;
    send_range(0, 0, 1'b1, 0, 5*W+3);
    send_range(2, 0, 1'b1, 0, W*H);
    drain();
    chk("t6a_count", 256'(win_cnt - start), 256'(4 + 16));
    chk("t6a_sb_empty", 256'(sb_q.size()), 256'(0));

    // 6b: same interruption by rst; next pixel is (0,0) without in_sof
    start = win_cnt;
    send_range(0, 0, 1'b1, 0, 5*W+3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_range(2, 0, 1'b0, 0, W*H);
    drain();
    chk("t6b_count", 256'(win_cnt - start), 256'(4 + 16));
    chk("t6b_sb_empty", 256'(sb_q.size()), 256'(0));

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
